// File: rtl/cdc_in_packetizer.sv
// UART RX byte FIFO that frames bytes into USB bulk IN packets, with NAK retry from a shadow read pointer.
// Optional zero-length packet after an exact MAX_PKT transfer: define CDC_IN_PKT_ZLP_EN.
module cdc_in_packetizer #(
  parameter int EP_NUM  = 2,
  parameter int DEPTH   = 1024,
  parameter int MAX_PKT = 512,
  parameter int TIMEOUT = 6000
) (
  input  logic                       hclk,
  input  logic                       reset,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [7:0]                 s_tdata,
  input  logic [3:0]                 usb_endpt,
  input  logic                       usb_txact,
  input  logic                       usb_txpop,
  input  logic                       usb_txpktfin,
  output logic                       usb_txcork,
  output logic [7:0]                 usb_txdata,
  output logic [11:0]                usb_txlen,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_PKT_P = PW'(MAX_PKT);
  localparam logic [11:0]   MAX_LEN   = 12'(MAX_PKT);
  localparam logic [TW-1:0] TIMEOUT_P = TW'(TIMEOUT);
  localparam logic [3:0]    EP_P      = 4'(EP_NUM);

  typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

  logic [7:0]    mem [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] sh_ptr_q, sh_ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cork_q, cork_d;
  logic [11:0]   txlen_q, txlen_d;
`ifdef CDC_IN_PKT_ZLP_EN
  logic          zlp_flag_q, zlp_flag_d;
`endif

  logic          wr_en;
  logic          sel;
  logic [PW-1:0] len_p;
  logic [PW-1:0] end_ptr;
  logic [PW-1:0] rd_addr;

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign s_tready   = ~reset & (fifo_level != DEPTH_P);
  assign wr_en      = s_tvalid & s_tready;
  assign sel        = usb_txact & (usb_endpt == EP_P);
  assign len_p      = PW'(txlen_q);
  assign end_ptr    = rd_ptr_q + len_p;

  // Once every byte has been popped, keep presenting the final payload byte
  assign rd_addr    = ((sh_ptr_q == end_ptr) && (txlen_q != 12'd0)) ? sh_ptr_q - PW'(1) : sh_ptr_q;

  assign usb_txdata = ((state_q == ARMED) || (state_q == SEND)) ? mem[rd_addr[AW-1:0]] : 8'h00;
  assign usb_txcork = cork_q;
  assign usb_txlen  = txlen_q;

  always_ff @(posedge hclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= s_tdata;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q;
    sh_ptr_d = sh_ptr_q;
    cork_d   = cork_q;
    txlen_d  = txlen_q;
    if (wr_en)                    timer_d = '0;
    else if (timer_q == TIMEOUT_P) timer_d = timer_q;
    else                          timer_d = timer_q + TW'(1);
`ifdef CDC_IN_PKT_ZLP_EN
    zlp_flag_d = zlp_flag_q & ~wr_en;
`endif

    case (state_q)
      IDLE: begin
        cork_d = 1'b1;
        if (fifo_level >= MAX_PKT_P) begin
          txlen_d  = MAX_LEN;
          sh_ptr_d = rd_ptr_q;
          cork_d   = 1'b0;
          state_d  = ARMED;
        end else if ((fifo_level != '0) && (timer_q == TIMEOUT_P)) begin
          txlen_d  = 12'(fifo_level);
          sh_ptr_d = rd_ptr_q;
          cork_d   = 1'b0;
          state_d  = ARMED;
        end
`ifdef CDC_IN_PKT_ZLP_EN
        else if (zlp_flag_q && (fifo_level == '0) && (timer_q == TIMEOUT_P)) begin
          txlen_d  = 12'd0;
          sh_ptr_d = rd_ptr_q;
          cork_d   = 1'b0;
          state_d  = ARMED;
        end
`endif
      end
      ARMED: begin
        cork_d = 1'b0;
        if (sel) state_d = SEND;
      end
      SEND: begin
        if (sel) begin
          if (usb_txpop && (sh_ptr_q != end_ptr)) sh_ptr_d = sh_ptr_q + PW'(1);
          if (usb_txpktfin) begin
            rd_ptr_d = end_ptr;
            cork_d   = 1'b1;
            state_d  = IDLE;
`ifdef CDC_IN_PKT_ZLP_EN
            if (txlen_q == 12'd0)
              zlp_flag_d = 1'b0;
            else if ((txlen_q == MAX_LEN) && (wr_ptr_d == end_ptr))
              zlp_flag_d = 1'b1;
`endif
          end
        end else begin
          // Host abandoned the transfer: rewind so the same packet is offered again
          sh_ptr_d = rd_ptr_q;
          state_d  = ARMED;
        end
      end
      default: begin
        cork_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sh_ptr_q   <= '0;
      timer_q    <= '0;
      cork_q     <= 1'b1;
      txlen_q    <= '0;
`ifdef CDC_IN_PKT_ZLP_EN
      zlp_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sh_ptr_q   <= sh_ptr_d;
      timer_q    <= timer_d;
      cork_q     <= cork_d;
      txlen_q    <= txlen_d;
`ifdef CDC_IN_PKT_ZLP_EN
      zlp_flag_q <= zlp_flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_in_packetizer.sv
// Directed bench for cdc_in_packetizer: timeout packets, full packets, NAK retry, back-pressure,
// foreign endpoint, asynchronous reset and the optional zero-length packet.
module tb_cdc_in_packetizer;

  localparam int EP_NUM  = 2;
  localparam int DEPTH   = 1024;
  localparam int MAX_PKT = 512;
  localparam int TIMEOUT = 6000;

  logic        hclk;
  logic        reset;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic [3:0]  usb_endpt;
  logic        usb_txact;
  logic        usb_txpop;
  logic        usb_txpktfin;
  logic        usb_txcork;
  logic [7:0]  usb_txdata;
  logic [11:0] usb_txlen;
  logic [10:0] fifo_level;

  int testsRun  = 0;
  int failCount = 0;

  cdc_in_packetizer #(
    .EP_NUM(EP_NUM), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)
  ) dut (
    .hclk(hclk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .usb_endpt(usb_endpt), .usb_txact(usb_txact), .usb_txpop(usb_txpop),
    .usb_txpktfin(usb_txpktfin), .usb_txcork(usb_txcork), .usb_txdata(usb_txdata),
    .usb_txlen(usb_txlen), .fifo_level(fifo_level)
  );

  // Free-running clock
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Byte patterns for the different test phases
  function automatic logic [7:0] expByte(input int kind, input int idx);
    logic [7:0] v;
    case (kind)
      0:       v = 8'h11 + 8'(idx);
      1:       v = 8'(idx * 7 + 3);
      default: v = 8'(idx) ^ 8'hA5;
    endcase
    return v;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Stream n bytes back-to-back from the chosen pattern
  task automatic applyStimulus(input int n, input int kind, input int base);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = expByte(kind, base + i);
      tick();
    end
    s_tvalid = 1'b0;
  endtask

  // Wait, with a cycle budget, for a packet to become ready
  task automatic waitArmed(input string tag, input int budget);
    int n = 0;
    while (usb_txcork && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, usb_txcork, 0);
  endtask

  // Host starts servicing our endpoint
  task automatic startService();
    usb_endpt = 4'(EP_NUM);
    usb_txact = 1'b1;
    tick();
  endtask

  // Pop n bytes, checking each presented byte first
  task automatic popCheck(input int n, input int kind, input int base);
    usb_txpop = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkOutput("pkt_data", usb_txdata, expByte(kind, base + i));
      tick();
    end
    usb_txpop = 1'b0;
  endtask

  // Host acknowledges the packet
  task automatic finishPacket();
    usb_txpktfin = 1'b1;
    tick();
    usb_txpktfin = 1'b0;
    usb_txact    = 1'b0;
    checkOutput("fin_cork", usb_txcork, 1);
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset        = 1'b1;
    s_tvalid     = 1'b0;
    s_tdata      = 8'h00;
    usb_endpt    = 4'd0;
    usb_txact    = 1'b0;
    usb_txpop    = 1'b0;
    usb_txpktfin = 1'b0;

    repeat (3) @(posedge hclk);
    #1;
    checkOutput("rst_tready", s_tready, 0);
    checkOutput("rst_cork",   usb_txcork, 1);
    checkOutput("rst_len",    usb_txlen, 0);
    checkOutput("rst_data",   usb_txdata, 0);
    checkOutput("rst_level",  fifo_level, 0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_tready", s_tready, 1);

    // Short packet released by idle timeout
    $display("[TB] short packet after timeout");
    applyStimulus(5, 0, 0);
    checkOutput("short_level", fifo_level, 5);
    repeat (TIMEOUT - 1) tick();
    checkOutput("short_cork_hold", usb_txcork, 1);
    tick();
    tick();
    checkOutput("short_cork_armed", usb_txcork, 0);
    checkOutput("short_len", usb_txlen, 5);
    startService();
    popCheck(5, 0, 0);
    usb_txpop = 1'b1;
    tick();
    usb_txpop = 1'b0;
    checkOutput("overpop_hold", usb_txdata, 8'h15);
    finishPacket();
    checkOutput("short_level_end", fifo_level, 0);

    // Fill to DEPTH unserviced, then drain full packets and a timed-out remainder
    $display("[TB] full packets and back-pressure");
    applyStimulus(DEPTH, 1, 0);
    checkOutput("full_tready", s_tready, 0);
    checkOutput("full_level",  fifo_level, DEPTH);
    checkOutput("full_cork",   usb_txcork, 0);
    checkOutput("full_len",    usb_txlen, MAX_PKT);
    startService();
    popCheck(MAX_PKT, 1, 0);
    finishPacket();
    checkOutput("after1_level",  fifo_level, 512);
    checkOutput("after1_tready", s_tready, 1);
    tick();
    checkOutput("rearm_cork", usb_txcork, 0);
    checkOutput("rearm_len",  usb_txlen, MAX_PKT);
    applyStimulus(76, 1, DEPTH);
    checkOutput("late_write_len", usb_txlen, MAX_PKT);
    startService();
    popCheck(MAX_PKT, 1, 512);
    finishPacket();
    checkOutput("after2_level", fifo_level, 76);
    waitArmed("tail_armed", TIMEOUT + 20);
    checkOutput("tail_len", usb_txlen, 76);
    startService();
    popCheck(76, 1, DEPTH);
    finishPacket();
    checkOutput("tail_level", fifo_level, 0);

    // Host abandons a packet partway through; it is re-offered from the start
    $display("[TB] retry after abandoned transfer");
    applyStimulus(MAX_PKT, 2, 0);
    tick();
    checkOutput("retry_cork", usb_txcork, 0);
    checkOutput("retry_len",  usb_txlen, MAX_PKT);
    startService();
    popCheck(100, 2, 0);
    usb_txact = 1'b0;
    tick();
    checkOutput("nak_level", fifo_level, MAX_PKT);
    checkOutput("nak_cork",  usb_txcork, 0);
    checkOutput("nak_len",   usb_txlen, MAX_PKT);
    checkOutput("nak_data0", usb_txdata, expByte(2, 0));
    startService();
    popCheck(MAX_PKT, 2, 0);
    finishPacket();
    checkOutput("retry_level_end", fifo_level, 0);

    // Exact MAX_PKT transfer just finished with an empty FIFO
`ifdef CDC_IN_PKT_ZLP_EN
    $display("[TB] zero-length packet");
    waitArmed("zlp_armed", TIMEOUT + 20);
    checkOutput("zlp_len", usb_txlen, 0);
    startService();
    finishPacket();
    checkOutput("zlp_level", fifo_level, 0);
    repeat (5) tick();
    checkOutput("zlp_cleared_cork", usb_txcork, 1);
`else
    $display("[TB] no zero-length packet");
    repeat (TIMEOUT + 20) tick();
    checkOutput("no_zlp_cork", usb_txcork, 1);
`endif

    // Foreign endpoint is ignored, then reset lands mid-SEND
    $display("[TB] foreign endpoint and async reset");
    applyStimulus(MAX_PKT, 1, 0);
    tick();
    checkOutput("ep3_armed", usb_txcork, 0);
    usb_endpt = 4'd3;
    usb_txact = 1'b1;
    usb_txpop = 1'b1;
    repeat (8) tick();
    usb_txpktfin = 1'b1;
    tick();
    usb_txpktfin = 1'b0;
    usb_txpop    = 1'b0;
    usb_txact    = 1'b0;
    checkOutput("ep3_cork",  usb_txcork, 0);
    checkOutput("ep3_level", fifo_level, MAX_PKT);
    checkOutput("ep3_data",  usb_txdata, expByte(1, 0));
    startService();
    usb_txpop = 1'b1;
    tick();
    tick();
    usb_txpop = 1'b0;
    checkOutput("send_data2", usb_txdata, expByte(1, 2));
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_cork",   usb_txcork, 1);
    checkOutput("async_rst_level",  fifo_level, 0);
    checkOutput("async_rst_tready", s_tready, 0);
    checkOutput("async_rst_len",    usb_txlen, 0);
    usb_txact = 1'b0;
    @(posedge hclk);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("final_tready", s_tready, 1);
    checkOutput("final_cork",   usb_txcork, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
